// File: rtl/mux_arb_nt1.sv
// mux_arb_nt1: N-to-1 W-bit channel multiplexer with a registered output stage.
// The granted channel is picked by fixed-priority or round-robin arbitration, or
// forced by force_sel. A multi-beat packet holds its grant until its last beat.
//
// Handshake: a beat moves across a port on a rising edge where valid and ready
// are both 1. Producers hold valid/data/last stable until accepted. in_ready is
// one-hot or zero and depends combinationally on out_ready (through load), never
// the other way. out_valid/out_data/out_last/out_sel are registered and stay
// stable while out_valid=1 and out_ready=0.
module mux_arb_nt1 #(
    parameter  int N  = 4,
    parameter  int W  = 32,
    parameter  int RR = 1,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    input  logic            force_en,
    input  logic [SW-1:0]   force_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_sel
);

    // Channel count at select width plus one, so indices and sums compare cleanly.
    localparam logic [SW:0] NUM = (SW+1)'(N);

    logic [SW-1:0] rr_ptr;     // first channel examined by the round-robin scan
    logic          lock;       // a multi-beat packet is in flight
    logic [SW-1:0] lock_sel;   // channel owning the in-flight packet

    logic          load;
    logic          xfer;
    logic          gnt_any;
    logic [SW-1:0] gnt_idx;
    logic [SW:0]   scan;
    logic [W-1:0]  gnt_data;
    logic          gnt_last;
    logic [SW-1:0] rr_next;

    // The output register may take a new beat when empty or being drained.
    assign load = ~out_valid | out_ready;

    // Pick the granted channel: lock beats force, force beats arbitration.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (lock) begin
            gnt_idx = lock_sel;
            gnt_any = in_valid[lock_sel];
        end else if (force_en) begin
            // Out-of-range forced index simply yields no grant.
            if ({1'b0, force_sel} < NUM) begin
                gnt_idx = force_sel;
                gnt_any = in_valid[force_sel];
            end
        end else if (RR == 0) begin
            // Descending scan so the lowest valid index wins.
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            // Descending offset scan so the smallest offset from rr_ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                scan = {1'b0, rr_ptr} + (SW+1)'(k);
                if (scan >= NUM) begin
                    scan = scan - NUM;
                end
                if (in_valid[scan[SW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan[SW-1:0];
                end
            end
        end
    end

    // Route the granted channel's data and last flag toward the output register.
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data = in_data[i*W +: W];
                gnt_last = in_last[i];
            end
        end
    end

    // No beat is accepted while reset is asserted.
    assign xfer = rst_n & load & gnt_any;

    // Acknowledge only the granted channel, and only when the beat moves.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer & (gnt_idx == SW'(i));
        end
    end

    // Round-robin pointer moves just past the channel that finished a packet.
    assign rr_next = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

    // Output register, packet lock and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_sel  <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_last  <= gnt_last;
                out_sel   <= gnt_idx;
                lock      <= ~gnt_last;
                lock_sel  <= gnt_idx;
                if ((RR != 0) && gnt_last) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                // Drained with nothing new: empty the stage, keep the payload.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nt1.sv
// tb_mux_arb_nt1: directed bench for mux_arb_nt1. Three instances cover
// round-robin N=4, fixed-priority N=4 and round-robin N=3.
module tb_mux_arb_nt1;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    // Instance A: N=4, RR=1
    logic [3:0]   a_v, a_ir, a_l;
    logic [127:0] a_d;
    logic         a_fe, a_r, a_ov, a_ol;
    logic [1:0]   a_fs, a_os;
    logic [31:0]  a_od;

    // Instance B: N=4, RR=0
    logic [3:0]   b_v, b_ir, b_l;
    logic [127:0] b_d;
    logic         b_fe, b_r, b_ov, b_ol;
    logic [1:0]   b_fs, b_os;
    logic [31:0]  b_od;

    // Instance C: N=3, RR=1
    logic [2:0]   c_v, c_ir, c_l;
    logic [95:0]  c_d;
    logic         c_fe, c_r, c_ov, c_ol;
    logic [1:0]   c_fs, c_os;
    logic [31:0]  c_od;

    // Expected beats: {sel[1:0], last, data[31:0]}
    logic [34:0] exp_q_a[$];
    logic [34:0] exp_q_b[$];
    logic [34:0] exp_q_c[$];

    mux_arb_nt1 #(.N(4), .W(32), .RR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_ready(a_ir), .in_data(a_d),
        .in_last(a_l), .force_en(a_fe), .force_sel(a_fs), .out_valid(a_ov),
        .out_ready(a_r), .out_data(a_od), .out_last(a_ol), .out_sel(a_os)
    );

    mux_arb_nt1 #(.N(4), .W(32), .RR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_ready(b_ir), .in_data(b_d),
        .in_last(b_l), .force_en(b_fe), .force_sel(b_fs), .out_valid(b_ov),
        .out_ready(b_r), .out_data(b_od), .out_last(b_ol), .out_sel(b_os)
    );

    mux_arb_nt1 #(.N(3), .W(32), .RR(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_v), .in_ready(c_ir), .in_data(c_d),
        .in_last(c_l), .force_en(c_fe), .force_sel(c_fs), .out_valid(c_ov),
        .out_ready(c_r), .out_data(c_od), .out_last(c_ol), .out_sel(c_os)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] pk(input logic [1:0] s, input logic l, input logic [31:0] d);
        return {s, l, d};
    endfunction

    function automatic logic [31:0] mk(input int c, input int i);
        return 32'h2000_0000 | 32'(c << 8) | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: compare each beat when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_r) begin
            chk("a_beat_expected", 64'(exp_q_a.size() != 0), 64'h1);
            if (exp_q_a.size() != 0) chk("a_beat", 64'(pk(a_os, a_ol, a_od)), 64'(exp_q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ov && b_r) begin
            chk("b_beat_expected", 64'(exp_q_b.size() != 0), 64'h1);
            if (exp_q_b.size() != 0) chk("b_beat", 64'(pk(b_os, b_ol, b_od)), 64'(exp_q_b.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_ov && c_r) begin
            chk("c_beat_expected", 64'(exp_q_c.size() != 0), 64'h1);
            if (exp_q_c.size() != 0) chk("c_beat", 64'(pk(c_os, c_ol, c_od)), 64'(exp_q_c.pop_front()));
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_v = '0; a_l = '0; a_d = '0; a_fe = 1'b0; a_fs = '0; a_r = 1'b1;
        b_v = '0; b_l = '0; b_d = '0; b_fe = 1'b0; b_fs = '0; b_r = 1'b1;
        c_v = '0; c_l = '0; c_d = '0; c_fe = 1'b0; c_fs = '0; c_r = 1'b1;

        // Reset state, with requests present during reset
        repeat (3) @(posedge clk);
        #1;
        a_v = 4'hF; a_l = 4'hF;
        #1;
        chk("rst_in_ready", 64'(a_ir), 64'h0);
        chk("rst_out_valid", 64'(a_ov), 64'h0);
        chk("rst_out_sel", 64'(a_os), 64'h0);
        chk("rst_out_data", 64'(a_od), 64'h0);
        chk("rst_out_last", 64'(a_ol), 64'h0);
        a_v = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin, all valid, single beats: 0,1,2,3,0 at one beat per cycle
        for (int c = 0; c < 5; c++) begin
            cyc();
            a_v = 4'hF; a_l = 4'hF;
            for (int i = 0; i < 4; i++) a_d[i*32 +: 32] = mk(c, i);
            #1;
            chk("rr_in_ready", 64'(a_ir), 64'(1 << (c % 4)));
            exp_q_a.push_back(pk(2'(c % 4), 1'b1, mk(c, c % 4)));
            if (c > 0) chk("rr_throughput", 64'(a_ov), 64'h1);
        end
        cyc();
        a_v = '0;
        chk("rr_last_out_valid", 64'(a_ov), 64'h1);
        cyc();
        chk("rr_idle", 64'(a_ov), 64'h0);

        // Fixed priority, in_valid=1010: channel 1 every cycle
        for (int c = 0; c < 4; c++) begin
            cyc();
            b_v = 4'b1010; b_l = 4'hF;
            b_d[32 +: 32] = 32'h8000_0000 + 32'(c);
            b_d[96 +: 32] = 32'h8300_0000 + 32'(c);
            #1;
            chk("fp_in_ready", 64'(b_ir), 64'h2);
            exp_q_b.push_back(pk(2'd1, 1'b1, 32'h8000_0000 + 32'(c)));
        end
        cyc();
        b_v = '0;

        // Packet lock: ch2 three beats while ch0 waits; force ignored while locked
        cyc();
        a_v = 4'b0101; a_l = 4'b0000;
        a_d[64 +: 32] = 32'h4200_0001; a_d[0 +: 32] = 32'h4000_0000;
        #1;
        chk("lock_beat1", 64'(a_ir), 64'h4);
        exp_q_a.push_back(pk(2'd2, 1'b0, 32'h4200_0001));
        cyc();
        a_l = 4'b0001; a_d[64 +: 32] = 32'h4200_0002; a_fe = 1'b1; a_fs = 2'd0;
        #1;
        chk("lock_beat2_force_ignored", 64'(a_ir), 64'h4);
        exp_q_a.push_back(pk(2'd2, 1'b0, 32'h4200_0002));
        cyc();
        a_l = 4'b0101; a_d[64 +: 32] = 32'h4200_0003; a_fe = 1'b0;
        #1;
        chk("lock_beat3", 64'(a_ir), 64'h4);
        exp_q_a.push_back(pk(2'd2, 1'b1, 32'h4200_0003));
        cyc();
        a_v = 4'b0001;
        #1;
        chk("lock_release_ch0", 64'(a_ir), 64'h1);
        exp_q_a.push_back(pk(2'd0, 1'b1, 32'h4000_0000));
        cyc();
        a_v = '0;

        // Locked channel drops valid mid-packet: no grant, bubble, lock held
        cyc();
        a_v = 4'b1010; a_l = 4'b0000;
        a_d[32 +: 32] = 32'h5100_0001; a_d[96 +: 32] = 32'h5300_0000;
        #1;
        chk("drop_first", 64'(a_ir), 64'h2);
        exp_q_a.push_back(pk(2'd1, 1'b0, 32'h5100_0001));
        cyc();
        a_v = 4'b1000;
        #1;
        chk("drop_no_grant", 64'(a_ir), 64'h0);
        cyc();
        chk("drop_bubble", 64'(a_ov), 64'h0);
        a_v = 4'b1010; a_l = 4'b1010; a_d[32 +: 32] = 32'h5100_0002;
        #1;
        chk("drop_resume", 64'(a_ir), 64'h2);
        exp_q_a.push_back(pk(2'd1, 1'b1, 32'h5100_0002));
        cyc();
        a_v = 4'b1000;
        #1;
        chk("drop_then_ch3", 64'(a_ir), 64'h8);
        exp_q_a.push_back(pk(2'd3, 1'b1, 32'h5300_0000));
        cyc();
        a_v = '0;

        // Backpressure: output held five cycles, then next beat follows
        cyc();
        a_v = 4'b0001; a_l = 4'b0011; a_d[0 +: 32] = 32'hDEAD_BEEF; a_r = 1'b0;
        #1;
        chk("bp_accept", 64'(a_ir), 64'h1);
        exp_q_a.push_back(pk(2'd0, 1'b1, 32'hDEAD_BEEF));
        for (int k = 0; k < 5; k++) begin
            cyc();
            a_v = 4'b0010; a_d[32 +: 32] = 32'h1111_1111;
            #1;
            chk("bp_in_ready", 64'(a_ir), 64'h0);
            chk("bp_out_valid", 64'(a_ov), 64'h1);
            chk("bp_out_data", 64'(a_od), 64'hDEAD_BEEF);
        end
        cyc();
        a_r = 1'b1;
        #1;
        chk("bp_release", 64'(a_ir), 64'h2);
        exp_q_a.push_back(pk(2'd1, 1'b1, 32'h1111_1111));
        cyc();
        a_v = '0;
        chk("bp_next_data", 64'(a_od), 64'h1111_1111);
        chk("bp_next_sel", 64'(a_os), 64'h1);

        // Forced select onto ch3 over live arbitration, then pointer follows it
        cyc();
        a_v = 4'hF; a_l = 4'hF;
        for (int i = 0; i < 3; i++) a_d[i*32 +: 32] = 32'h6000_0000 + 32'(i);
        a_d[96 +: 32] = 32'h1234_5678;
        a_fe = 1'b1; a_fs = 2'd3;
        #1;
        chk("force_in_ready", 64'(a_ir), 64'h8);
        exp_q_a.push_back(pk(2'd3, 1'b1, 32'h1234_5678));
        cyc();
        a_fe = 1'b0;
        chk("force_out_data", 64'(a_od), 64'h1234_5678);
        chk("force_out_sel", 64'(a_os), 64'h3);
        #1;
        chk("force_rr_wrap", 64'(a_ir), 64'h1);
        exp_q_a.push_back(pk(2'd0, 1'b1, 32'h6000_0000));
        cyc();
        a_v = 4'b1011; a_fe = 1'b1; a_fs = 2'd2;
        #1;
        chk("force_invalid_ch", 64'(a_ir), 64'h0);
        cyc();
        a_fe = 1'b0; a_v = '0;
        chk("force_invalid_idle", 64'(a_ov), 64'h0);

        // N=3: out-of-range force gives no grant; in-range force and wrap
        cyc();
        c_v = 3'b111; c_l = 3'b111; c_fe = 1'b1; c_fs = 2'd3;
        for (int i = 0; i < 3; i++) c_d[i*32 +: 32] = 32'h9000_0000 + 32'(i);
        #1;
        chk("n3_force_oor", 64'(c_ir), 64'h0);
        cyc();
        chk("n3_force_oor_idle", 64'(c_ov), 64'h0);
        c_fs = 2'd2;
        #1;
        chk("n3_force_ch2", 64'(c_ir), 64'h4);
        exp_q_c.push_back(pk(2'd2, 1'b1, 32'h9000_0002));
        cyc();
        c_fe = 1'b0;
        #1;
        chk("n3_rr_wrap", 64'(c_ir), 64'h1);
        exp_q_c.push_back(pk(2'd0, 1'b1, 32'h9000_0000));
        cyc();
        c_v = '0;
        cyc();
        chk("n3_idle", 64'(c_ov), 64'h0);

        // Async reset mid-cycle with a held beat and a locked packet
        cyc();
        a_v = 4'b0010; a_l = 4'b0000; a_d[32 +: 32] = 32'h7100_0001; a_r = 1'b0;
        #1;
        chk("prerst_accept", 64'(a_ir), 64'h2);
        exp_q_a.push_back(pk(2'd1, 1'b0, 32'h7100_0001));
        cyc();
        a_v = 4'hF; a_l = 4'hF;
        #1;
        chk("prerst_out_valid", 64'(a_ov), 64'h1);
        chk("prerst_in_ready", 64'(a_ir), 64'h0);
        #1;
        rst_n = 1'b0;
        exp_q_a.delete();
        #1;
        chk("midrst_out_valid", 64'(a_ov), 64'h0);
        chk("midrst_out_sel", 64'(a_os), 64'h0);
        chk("midrst_in_ready", 64'(a_ir), 64'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        a_v = 4'b0011; a_l = 4'b0011; a_r = 1'b1;
        a_d[0 +: 32] = 32'h7200_0000; a_d[32 +: 32] = 32'h7200_0001;
        #1;
        chk("postrst_grant", 64'(a_ir), 64'h1);
        exp_q_a.push_back(pk(2'd0, 1'b1, 32'h7200_0000));
        cyc();
        a_v = '0;
        cyc();
        chk("postrst_idle", 64'(a_ov), 64'h0);

        repeat (2) cyc();
        chk("a_queue_drained", 64'(exp_q_a.size()), 64'h0);
        chk("b_queue_drained", 64'(exp_q_b.size()), 64'h0);
        chk("c_queue_drained", 64'(exp_q_c.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
